// File: rtl/spi_sample_rx_if.sv
`timescale 1ns/1ps
// Output channel of spi_sample_rx: one received sample plus its valid/ready handshake.
interface spi_sample_rx_if #(
   parameter int FRAME_BITS = 11
);
   logic                  out_valid;
   logic                  out_ready;
   logic                  out_sign;
   logic [FRAME_BITS-2:0] out_mag;
   logic [FRAME_BITS-1:0] out_2c;

   modport master (
      output out_valid,
      output out_sign,
      output out_mag,
      output out_2c,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_sign,
      input  out_mag,
      input  out_2c,
      output out_ready
   );
endinterface

// File: rtl/spi_sample_rx.sv
`timescale 1ns/1ps
// SPI slave receiver for sign-magnitude sample frames, oversampled in the clk domain.
// Latency: ncs pin rise to out_valid/frame_err high is SYNC_STAGES+2 clk.
// Backpressure: one-entry output register; a new frame overwrites unread data and sets overrun.
module spi_sample_rx #(
   parameter int FRAME_BITS  = 11,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                sclk,
   input  logic                sdi,
   input  logic                ncs,
   input  logic                ovr_clear,
   spi_sample_rx_if.master     outIf,
   output logic                frame_err,
   output logic                overrun,
   output logic [15:0]         frame_cnt,
   output logic [7:0]          err_cnt
);

   localparam int CNT_W = $clog2(FRAME_BITS + 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

   typedef enum logic [1:0] {
      WAIT_IDLE,
      IDLE,
      SHIFT,
      CHECK
   } state_t;

   typedef struct packed {
      logic                  sign;
      logic [FRAME_BITS-2:0] mag;
   } sample_t;

   // Synchronisers reset to 0 so a low ncs at reset release never looks like a frame start.
   logic [SYNC_STAGES-1:0] sclkSync;
   logic [SYNC_STAGES-1:0] sdiSync;
   logic [SYNC_STAGES-1:0] ncsSync;
   logic                   sclkHist;
   logic                   ncsHist;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sclkSync <= '0;
         sdiSync  <= '0;
         ncsSync  <= '0;
         sclkHist <= 1'b0;
         ncsHist  <= 1'b0;
      end else begin
         sclkSync <= {sclkSync[SYNC_STAGES-2:0], sclk};
         sdiSync  <= {sdiSync[SYNC_STAGES-2:0], sdi};
         ncsSync  <= {ncsSync[SYNC_STAGES-2:0], ncs};
         sclkHist <= sclkSync[SYNC_STAGES-1];
         ncsHist  <= ncsSync[SYNC_STAGES-1];
      end
   end

   logic sclkS;
   logic sdiS;
   logic ncsS;
   logic sclkRise;
   logic ncsFall;
   logic ncsRise;

   assign sclkS    = sclkSync[SYNC_STAGES-1];
   assign sdiS     = sdiSync[SYNC_STAGES-1];
   assign ncsS     = ncsSync[SYNC_STAGES-1];
   assign sclkRise = sclkS & ~sclkHist;
   assign ncsFall  = ~ncsS & ncsHist;
   assign ncsRise  = ncsS & ~ncsHist;

   state_t state;
   state_t stateNext;
   logic   clearShift;
   logic   shiftEn;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= WAIT_IDLE;
      end else begin
         state <= stateNext;
      end
   end

   always_comb begin
      stateNext  = state;
      clearShift = 1'b0;
      shiftEn    = 1'b0;
      case (state)
         WAIT_IDLE: begin
            if (ncsS) begin
               stateNext = IDLE;
            end
         end
         IDLE: begin
            if (ncsFall) begin
               clearShift = 1'b1;
               stateNext  = SHIFT;
            end
         end
         SHIFT: begin
            // An sclk edge coinciding with the ncs rise is dropped, not counted.
            if (ncsRise) begin
               stateNext = CHECK;
            end else if (sclkRise) begin
               shiftEn = 1'b1;
            end
         end
         CHECK: begin
            stateNext = IDLE;
         end
         default: begin
            stateNext = WAIT_IDLE;
         end
      endcase
   end

   logic [FRAME_BITS-1:0] shiftReg;
   logic [CNT_W-1:0]      bitCnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shiftReg <= '0;
         bitCnt   <= '0;
      end else if (clearShift) begin
         shiftReg <= '0;
         bitCnt   <= '0;
      end else if (shiftEn) begin
         shiftReg <= {shiftReg[FRAME_BITS-2:0], sdiS};
         if (bitCnt != CNT_SAT) begin
            bitCnt <= bitCnt + CNT_W'(1);
         end
      end
   end

   sample_t               rxSample;
   logic [FRAME_BITS-1:0] magExt;
   logic [FRAME_BITS-1:0] rx2c;
   logic                  commit;
   logic                  reject;

   // Negating a zero magnitude yields zero, so negative zero maps to 0 naturally.
   assign rxSample = sample_t'(shiftReg);
   assign magExt   = {1'b0, rxSample.mag};
   assign rx2c     = rxSample.sign ? -magExt : magExt;
   assign commit   = (state == CHECK) && (bitCnt == CNT_FULL);
   assign reject   = (state == CHECK) && (bitCnt != CNT_FULL);

   logic                  outValidQ;
   logic                  outSignQ;
   logic [FRAME_BITS-2:0] outMagQ;
   logic [FRAME_BITS-1:0] out2cQ;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         outValidQ <= 1'b0;
         outSignQ  <= 1'b0;
         outMagQ   <= '0;
         out2cQ    <= '0;
         frame_cnt <= '0;
      end else if (commit) begin
         outValidQ <= 1'b1;
         outSignQ  <= rxSample.sign;
         outMagQ   <= rxSample.mag;
         out2cQ    <= rx2c;
         frame_cnt <= frame_cnt + 16'd1;
      end else if (outValidQ && outIf.out_ready) begin
         outValidQ <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overrun   <= 1'b0;
         frame_err <= 1'b0;
         err_cnt   <= '0;
      end else begin
         frame_err <= reject;
         if (commit && outValidQ && !outIf.out_ready) begin
            overrun <= 1'b1;
         end else if (ovr_clear) begin
            overrun <= 1'b0;
         end
         if (reject && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
         end
      end
   end

   assign outIf.out_valid = outValidQ;
   assign outIf.out_sign  = outSignQ;
   assign outIf.out_mag   = outMagQ;
   assign outIf.out_2c    = out2cQ;

endmodule

// File: tb/tb_spi_sample_rx.sv
`timescale 1ns/1ps
// Bench for spi_sample_rx: vector table for single frames, hand sequences for overrun/reset cases,
// and a commit-time scoreboard.
module tb_spi_sample_rx;
   localparam int FB = 11;

   logic        clk = 1'b0;
   logic        reset;
   logic        sclk;
   logic        sdi;
   logic        ncs;
   logic        ovr_clear;
   logic        frame_err;
   logic        overrun;
   logic [15:0] frame_cnt;
   logic [7:0]  err_cnt;

   spi_sample_rx_if #(.FRAME_BITS(FB)) oIf ();

   spi_sample_rx #(.FRAME_BITS(FB), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .sclk      (sclk),
      .sdi       (sdi),
      .ncs       (ncs),
      .ovr_clear (ovr_clear),
      .outIf     (oIf),
      .frame_err (frame_err),
      .overrun   (overrun),
      .frame_cnt (frame_cnt),
      .err_cnt   (err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        sign;
      logic [9:0]  mag;
      logic [10:0] twoC;
   } exp_t;

   typedef struct {
      int          nbits;
      logic [11:0] data;
      logic        expCommit;
      logic        expErr;
      logic        expSign;
      logic [9:0]  expMag;
      logic [10:0] exp2c;
      int          expFrames;
      int          expErrs;
   } vec_t;

   exp_t sbQ[$];
   vec_t vecs[5];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic exp_t mkExp(input logic [10:0] d);
      exp_t e;
      e.sign = d[10];
      e.mag  = d[9:0];
      e.twoC = d[10] ? (11'd0 - {1'b0, d[9:0]}) : {1'b0, d[9:0]};
      return e;
   endfunction

   // Starts and ends on a negedge; data changes with the sclk fall.
   task automatic sendBits(input int n, input logic [11:0] data, input int half);
      for (int i = n - 1; i >= 0; i--) begin
         sdi = data[i];
         repeat (half) @(negedge clk);
         sclk = 1'b1;
         repeat (half) @(negedge clk);
         sclk = 1'b0;
      end
   endtask

   task automatic sendFrame(input int n, input logic [11:0] data, input int half);
      @(negedge clk);
      ncs = 1'b0;
      repeat (4) @(negedge clk);
      sendBits(n, data, half);
      repeat (4) @(negedge clk);
      ncs = 1'b1;
   endtask

   initial begin : monitor
      logic [15:0] prevCnt;
      exp_t        e;
      prevCnt = '0;
      forever begin
         @(posedge clk);
         #1;
         if (reset) begin
            prevCnt = '0;
         end else if (frame_cnt != prevCnt) begin
            prevCnt = frame_cnt;
            if (sbQ.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected: commit at frame_cnt=%0d, required no commit", frame_cnt);
            end else begin
               e = sbQ.pop_front();
               chk("sb_valid", 32'(oIf.out_valid), 32'd1);
               chk("sb_sign", 32'(oIf.out_sign), 32'(e.sign));
               chk("sb_mag", 32'(oIf.out_mag), 32'(e.mag));
               chk("sb_2c", 32'(oIf.out_2c), 32'(e.twoC));
            end
         end
      end
   end

   initial begin : watchdog
      #5000000;
      $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   initial begin : main
      logic        sawValid;
      int          errPulses;
      logic [10:0] d;
      exp_t        e;

      vecs[0] = '{11, 12'h155, 1'b1, 1'b0, 1'b0, 10'h155, 11'h155, 1, 0};
      vecs[1] = '{11, 12'h403, 1'b1, 1'b0, 1'b1, 10'h003, 11'h7FD, 2, 0};
      vecs[2] = '{11, 12'h400, 1'b1, 1'b0, 1'b1, 10'h000, 11'h000, 3, 0};
      vecs[3] = '{10, 12'h2AA, 1'b0, 1'b1, 1'b1, 10'h000, 11'h000, 3, 1};
      vecs[4] = '{12, 12'hABC, 1'b0, 1'b1, 1'b1, 10'h000, 11'h000, 3, 2};

      reset         = 1'b1;
      sclk          = 1'b0;
      sdi           = 1'b0;
      ncs           = 1'b1;
      ovr_clear     = 1'b0;
      oIf.out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("rst_valid", 32'(oIf.out_valid), 32'd0);
      chk("rst_sign", 32'(oIf.out_sign), 32'd0);
      chk("rst_mag", 32'(oIf.out_mag), 32'd0);
      chk("rst_2c", 32'(oIf.out_2c), 32'd0);
      chk("rst_ferr", 32'(frame_err), 32'd0);
      chk("rst_ovr", 32'(overrun), 32'd0);
      chk("rst_fcnt", 32'(frame_cnt), 32'd0);
      chk("rst_ecnt", 32'(err_cnt), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (10) @(negedge clk);

      foreach (vecs[i]) begin
         if (vecs[i].expCommit) begin
            e.sign = vecs[i].expSign;
            e.mag  = vecs[i].expMag;
            e.twoC = vecs[i].exp2c;
            sbQ.push_back(e);
         end
         sendFrame(vecs[i].nbits, vecs[i].data, 32);
         sawValid  = 1'b0;
         errPulses = 0;
         for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            if (oIf.out_valid) sawValid = 1'b1;
            if (frame_err) errPulses++;
            if (vecs[i].expCommit && c == 3) chk("lat_before4", 32'(oIf.out_valid), 32'd0);
            if (vecs[i].expCommit && c == 4) chk("lat_at4", 32'(oIf.out_valid), 32'd1);
         end
         chk("vec_valid", 32'(sawValid), 32'(vecs[i].expCommit));
         chk("vec_ferr", 32'(errPulses), 32'(vecs[i].expErr));
         chk("vec_sign", 32'(oIf.out_sign), 32'(vecs[i].expSign));
         chk("vec_mag", 32'(oIf.out_mag), 32'(vecs[i].expMag));
         chk("vec_2c", 32'(oIf.out_2c), 32'(vecs[i].exp2c));
         chk("vec_fcnt", 32'(frame_cnt), 32'(vecs[i].expFrames));
         chk("vec_ecnt", 32'(err_cnt), 32'(vecs[i].expErrs));
         repeat (4) @(negedge clk);
      end

      // Overrun: two frames with the consumer stalled.
      oIf.out_ready = 1'b0;
      sbQ.push_back(mkExp(11'h0AA));
      sendFrame(11, 12'h0AA, 32);
      repeat (8) @(posedge clk);
      #1;
      chk("ovr_pre", 32'(overrun), 32'd0);
      chk("ovr_held", 32'(oIf.out_valid), 32'd1);
      sbQ.push_back(mkExp(11'h1FF));
      sendFrame(11, 12'h1FF, 32);
      repeat (8) @(posedge clk);
      #1;
      chk("ovr_set", 32'(overrun), 32'd1);
      chk("ovr_mag", 32'(oIf.out_mag), 32'h1FF);
      chk("ovr_valid", 32'(oIf.out_valid), 32'd1);
      @(negedge clk);
      ovr_clear = 1'b1;
      @(posedge clk);
      #1;
      chk("ovr_clear", 32'(overrun), 32'd0);
      @(negedge clk);
      ovr_clear     = 1'b0;
      oIf.out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("hs_drain", 32'(oIf.out_valid), 32'd0);
      chk("ovr_fcnt", 32'(frame_cnt), 32'd5);

      // ncs held low across reset release: the partial frame must be ignored.
      @(negedge clk);
      reset = 1'b1;
      ncs   = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      sendBits(6, 12'h02D, 32);
      repeat (4) @(negedge clk);
      ncs = 1'b1;
      errPulses = 0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (frame_err) errPulses++;
      end
      chk("midrst_ferr", 32'(errPulses), 32'd0);
      chk("midrst_fcnt", 32'(frame_cnt), 32'd0);
      chk("midrst_ecnt", 32'(err_cnt), 32'd0);
      chk("midrst_valid", 32'(oIf.out_valid), 32'd0);
      repeat (4) @(negedge clk);
      sbQ.push_back(mkExp(11'h2F0));
      sendFrame(11, 12'h2F0, 32);
      repeat (8) @(posedge clk);
      #1;
      chk("after_fcnt", 32'(frame_cnt), 32'd1);
      chk("after_mag", 32'(oIf.out_mag), 32'h2F0);

      // Reset asserted at bit 5 clears outputs immediately.
      @(negedge clk);
      ncs = 1'b0;
      repeat (4) @(negedge clk);
      sendBits(5, 12'h015, 32);
      #3;
      reset = 1'b1;
      #1;
      chk("arst_valid", 32'(oIf.out_valid), 32'd0);
      chk("arst_sign", 32'(oIf.out_sign), 32'd0);
      chk("arst_mag", 32'(oIf.out_mag), 32'd0);
      chk("arst_2c", 32'(oIf.out_2c), 32'd0);
      chk("arst_ferr", 32'(frame_err), 32'd0);
      chk("arst_ovr", 32'(overrun), 32'd0);
      chk("arst_fcnt", 32'(frame_cnt), 32'd0);
      chk("arst_ecnt", 32'(err_cnt), 32'd0);
      repeat (3) @(negedge clk);
      ncs = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (10) @(negedge clk);

      // Bulk run at a faster sclk with random samples.
      for (int n = 0; n < 300; n++) begin
         d = 11'($urandom_range(0, 2047));
         sbQ.push_back(mkExp(d));
         sendFrame(11, {1'b0, d}, 8);
         repeat (6) @(negedge clk);
      end
      repeat (10) @(posedge clk);
      #1;
      chk("bulk_fcnt", 32'(frame_cnt), 32'd300);
      chk("bulk_ecnt", 32'(err_cnt), 32'd0);
      chk("sb_empty", 32'(sbQ.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
